mips_mc_ctrl: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/mips_imm_alusel.sv | 27 ++
 rtl/mips_mc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS control FSM
//
// Purpose: state enumeration, opcode constants, ALU selector codes and
// datapath mux codes used by mips_mc_ctrl and mips_imm_alusel.
// Ports: none (package).

package mips_ctrl_pkg;

    // Encoding order is also the value visible on the State debug port.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        WB_R     = 4'd8,
        EXEC_I   = 4'd9,
        WB_I     = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch out of DECODE; anything not recognised lands in TRAP.
    function automatic state_t decode_dispatch(input logic [5:0] opcode);
        state_t nxt;
        case (opcode)
            OP_RTYPE:                         nxt = EXEC_R;
            OP_LW, OP_SW:                     nxt = MEM_ADDR;
            OP_BEQ:                           nxt = BRANCH;
            OP_J:                             nxt = JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = EXEC_I;
            default:                          nxt = TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_imm_alusel.sv
// rtl/mips_imm_alusel.sv - opcode to ALU selector map for immediate-type instructions
//
// Purpose: combinational choice of the ALU operation used in EXEC_I.
// Ports:
//   opcode  in  6  instruction opcode field (held stable by the IR)
//   alu_sel out 3  ALU selector for the immediate operation

module mips_imm_alusel
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] alu_sel
);

    // addi and any non-immediate opcode fall back to ADD; the control FSM
    // only consumes this value while in EXEC_I.
    always_comb begin
        alu_sel = ALU_ADD;
        case (opcode)
            OP_ANDI: alu_sel = ALU_AND;
            OP_ORI:  alu_sel = ALU_OR;
            OP_SLTI: alu_sel = ALU_SLT;
            default: alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - main control FSM for the multicycle MIPS datapath
//
// Purpose: sequences fetch/decode/execute/memory/writeback, drives datapath
// mux selects and enables, counts retired instructions, traps on bad opcodes.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   Opcode[5:0]       IR[31:26]
//   Zero              ALU zero flag (consumed by datapath via PcWriteCond)
//   MemReady          memory access completes in the cycle it is 1
//   PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite,
//   MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB[1:0], PcSrc[1:0],
//   AluSel[2:0]       datapath controls
//   Retire            one-cycle pulse when an instruction completes
//   InstrCount        retired instruction count, wraps modulo 2^CNT_W
//   Illegal           sticky illegal-opcode flag
//   State[3:0]        current state for debug

module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PcWrite,
    output logic             PcWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IrWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       PcSrc,
    output logic [2:0]       AluSel,
    output logic             Retire,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Illegal,
    output logic [3:0]       State
);

    state_t     state;
    state_t     next_state;
    logic [2:0] imm_alu_sel;

    // Zero is only meaningful to the datapath (gated by PcWriteCond there).
    logic unused_zero;
    assign unused_zero = Zero;

    mips_imm_alusel u_imm_alusel (
        .opcode  (Opcode),
        .alu_sel (imm_alu_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrCount <= '0;
        end else if (Retire) begin
            InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    // TRAP is absorbing, so setting on entry is equivalent to sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Illegal <= 1'b0;
        end else if (next_state == TRAP) begin
            Illegal <= 1'b1;
        end
    end

    assign State = state;

    always_comb begin
        next_state  = state;
        PcWrite     = 1'b0;
        PcWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IrWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = SRCB_REGB;
        PcSrc       = PCSRC_ALU;
        AluSel      = ALU_FUNCT;
        Retire      = 1'b0;

        case (state)
            IDLE: begin
                next_state = FETCH;
            end
            FETCH: begin
                // PC+4 is computed every cycle; it is only committed with the IR.
                MemRead = 1'b1;
                AluSrcB = SRCB_FOUR;
                AluSel  = ALU_ADD;
                if (MemReady) begin
                    IrWrite    = 1'b1;
                    PcWrite    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                // Speculative branch target into ALUOut.
                AluSrcB    = SRCB_IMM_SH2;
                AluSel     = ALU_ADD;
                next_state = decode_dispatch(Opcode);
            end
            MEM_ADDR: begin
                AluSrcA    = 1'b1;
                AluSrcB    = SRCB_IMM;
                AluSel     = ALU_ADD;
                next_state = (Opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) begin
                    next_state = MEM_WB;
                end
            end
            MEM_WB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                Retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    Retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            EXEC_R: begin
                AluSrcA    = 1'b1;
                AluSel     = ALU_FUNCT;
                next_state = WB_R;
            end
            WB_R: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                Retire     = 1'b1;
                next_state = FETCH;
            end
            EXEC_I: begin
                AluSrcA    = 1'b1;
                AluSrcB    = SRCB_IMM;
                AluSel     = imm_alu_sel;
                next_state = WB_I;
            end
            WB_I: begin
                RegWrite   = 1'b1;
                Retire     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                AluSrcA     = 1'b1;
                AluSel      = ALU_SUB;
                PcWriteCond = 1'b1;
                PcSrc       = PCSRC_ALUOUT;
                Retire      = 1'b1;
                next_state  = FETCH;
            end
            JUMP: begin
                PcWrite    = 1'b1;
                PcSrc      = PCSRC_JUMP;
                Retire     = 1'b1;
                next_state = FETCH;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - self-checking bench for mips_mc_ctrl

module tb_mips_mc_ctrl;

    localparam int CW = 4;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                   S_MEM_RD = 4, S_MEM_WB = 5, S_MEM_WR = 6, S_EXEC_R = 7,
                   S_WB_R = 8, S_EXEC_I = 9, S_WB_I = 10, S_BRANCH = 11,
                   S_JUMP = 12, S_TRAP = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    Opcode;
    logic          Zero;
    logic          MemReady;
    logic          PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite;
    logic          MemToReg, RegDst, RegWrite, AluSrcA, Retire, Illegal;
    logic [1:0]    AluSrcB, PcSrc;
    logic [2:0]    AluSel;
    logic [CW-1:0] InstrCount;
    logic [3:0]    State;
    logic [17:0]   obs;

    int n_checks;
    int n_fail;
    int cnt_model;
    int seq_q[$];
    int rq_q[$];

    always #5 clk = ~clk;

    mips_mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PcWrite(PcWrite), .PcWriteCond(PcWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IrWrite(IrWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PcSrc(PcSrc),
        .AluSel(AluSel), .Retire(Retire), .InstrCount(InstrCount), .Illegal(Illegal),
        .State(State)
    );

    assign obs = {PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IrWrite, MemToReg,
                  RegDst, RegWrite, AluSrcA, AluSrcB, PcSrc, AluSel, Retire};

    // Output table per state, straight from the control description.
    function automatic logic [17:0] exp_outs(input int st, input logic [5:0] op, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, ret;
        logic [1:0] sb, ps;
        logic [2:0] sel;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, ret} = '0;
        sb = 2'b00; ps = 2'b00; sel = 3'b000;
        case (st)
            S_FETCH:    begin mr = 1; sb = 2'b01; sel = 3'b001; irw = rdy; pcw = rdy; end
            S_DECODE:   begin sb = 2'b11; sel = 3'b001; end
            S_MEM_ADDR: begin sa = 1; sb = 2'b10; sel = 3'b001; end
            S_MEM_RD:   begin mr = 1; iord = 1; end
            S_MEM_WB:   begin m2r = 1; rw = 1; ret = 1; end
            S_MEM_WR:   begin mw = 1; iord = 1; ret = rdy; end
            S_EXEC_R:   begin sa = 1; end
            S_WB_R:     begin rd = 1; rw = 1; ret = 1; end
            S_EXEC_I:   begin
                sa = 1; sb = 2'b10;
                sel = (op == 6'b001100) ? 3'd3 : (op == 6'b001101) ? 3'd4 :
                      (op == 6'b001010) ? 3'd5 : 3'd1;
            end
            S_WB_I:     begin rw = 1; ret = 1; end
            S_BRANCH:   begin sa = 1; sel = 3'b010; pcwc = 1; ps = 2'b01; ret = 1; end
            S_JUMP:     begin pcw = 1; ps = 2'b10; ret = 1; end
            default:    begin end
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, sel, ret};
    endfunction

    // rdy: 0 = force low, 1 = force high, 2 = random (must not matter)
    function automatic void add(input int s, input int r);
        seq_q.push_back(s);
        rq_q.push_back(r);
    endfunction

    // Runs one instruction from FETCH entry to the last state before the next FETCH.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        logic [17:0] e;
        seq_q.delete();
        rq_q.delete();
        repeat (fw) add(S_FETCH, 0);
        add(S_FETCH, 1);
        add(S_DECODE, 2);
        case (op)
            6'b000000: begin add(S_EXEC_R, 2); add(S_WB_R, 2); end
            6'b100011: begin
                add(S_MEM_ADDR, 2);
                repeat (mw) add(S_MEM_RD, 0);
                add(S_MEM_RD, 1);
                add(S_MEM_WB, 2);
            end
            6'b101011: begin
                add(S_MEM_ADDR, 2);
                repeat (mw) add(S_MEM_WR, 0);
                add(S_MEM_WR, 1);
            end
            6'b000100: add(S_BRANCH, 2);
            6'b000010: add(S_JUMP, 2);
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin add(S_EXEC_I, 2); add(S_WB_I, 2); end
            default: add(S_TRAP, 2);
        endcase
        foreach (seq_q[k]) begin
            @(negedge clk);
            Opcode   = op;
            MemReady = (rq_q[k] == 2) ? 1'($urandom_range(0, 1)) : 1'(rq_q[k]);
            Zero     = 1'($urandom_range(0, 1));
            #1;
            e = exp_outs(seq_q[k], op, MemReady);
            n_checks++;
            if (State !== 4'(seq_q[k])) begin
                n_fail++;
                $display("FAIL state op=%b step=%0d got=%0d want=%0d", op, k, State, seq_q[k]);
            end
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL outputs op=%b step=%0d got=%b want=%b", op, k, obs, e);
            end
            n_checks++;
            if (InstrCount !== CW'(cnt_model)) begin
                n_fail++;
                $display("FAIL instr_count op=%b step=%0d got=%0d want=%0d", op, k, InstrCount, cnt_model);
            end
            n_checks++;
            if (Illegal !== 1'(seq_q[k] == S_TRAP)) begin
                n_fail++;
                $display("FAIL illegal op=%b step=%0d got=%b want=%b", op, k, Illegal, seq_q[k] == S_TRAP);
            end
            if (e[0]) cnt_model = (cnt_model + 1) % (1 << CW);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        MemReady = 1'b1;
        #1;
        n_checks++;
        if (obs !== 18'd0) begin n_fail++; $display("FAIL reset_outputs got=%b want=0", obs); end
        n_checks++;
        if (State !== 4'(S_IDLE)) begin n_fail++; $display("FAIL reset_state got=%0d want=0", State); end
        n_checks++;
        if (InstrCount !== '0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", InstrCount); end
        n_checks++;
        if (Illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b want=0", Illegal); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (State !== 4'(S_IDLE)) begin n_fail++; $display("FAIL release_state got=%0d want=0", State); end
        cnt_model = 0;
    endtask

    task automatic test_r_type;
        run_instr(6'b000000, 0, 0);
        @(posedge clk); #1;
        n_checks++;
        if (InstrCount !== CW'(1)) begin n_fail++; $display("FAIL r_count got=%0d want=1", InstrCount); end
        n_checks++;
        if (State !== 4'(S_FETCH)) begin n_fail++; $display("FAIL r_refetch got=%0d want=1", State); end
    endtask

    task automatic test_lw_waits;
        run_instr(6'b100011, 2, 3);
        @(posedge clk); #1;
        n_checks++;
        if (InstrCount !== CW'(2)) begin n_fail++; $display("FAIL lw_count got=%0d want=2", InstrCount); end
    endtask

    task automatic test_sw_beq;
        run_instr(6'b101011, 0, 1);
        run_instr(6'b000100, 0, 0);
        @(posedge clk); #1;
        n_checks++;
        if (InstrCount !== CW'(4)) begin n_fail++; $display("FAIL sw_beq_count got=%0d want=4", InstrCount); end
    endtask

    task automatic test_itype_jump;
        run_instr(6'b001000, 0, 0);
        run_instr(6'b001100, 1, 0);
        run_instr(6'b001101, 0, 0);
        run_instr(6'b001010, 0, 0);
        run_instr(6'b000010, 0, 0);
        @(posedge clk); #1;
        n_checks++;
        if (InstrCount !== CW'(9)) begin n_fail++; $display("FAIL itype_count got=%0d want=9", InstrCount); end
    endtask

    task automatic test_random;
        logic [5:0] ops [9];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                6'b001000, 6'b001100, 6'b001101, 6'b001010};
        for (int i = 0; i < 25; i++) begin
            run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    task automatic test_trap;
        int held;
        run_instr(6'b111111, 0, 0);
        held = cnt_model;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            Opcode   = 6'($urandom_range(0, 63));
            MemReady = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (State !== 4'(S_TRAP) || Illegal !== 1'b1 || obs !== 18'd0) begin
                n_fail++;
                $display("FAIL trap_hold cyc=%0d got state=%0d ill=%b out=%b want 13/1/0", i, State, Illegal, obs);
            end
        end
        n_checks++;
        if (InstrCount !== CW'(held)) begin n_fail++; $display("FAIL trap_count got=%0d want=%0d", InstrCount, held); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (Illegal !== 1'b0 || State !== 4'(S_IDLE) || InstrCount !== '0) begin
            n_fail++;
            $display("FAIL trap_reset got ill=%b state=%0d cnt=%0d want 0/0/0", Illegal, State, InstrCount);
        end
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_model = 0;
        repeat (17) run_instr(6'b000010, 0, 0);
        @(posedge clk); #1;
        n_checks++;
        if (InstrCount !== CW'(1)) begin n_fail++; $display("FAIL wrap_count got=%0d want=1", InstrCount); end
    endtask

    task automatic test_async_abort;
        @(negedge clk); Opcode = 6'b100011; MemReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); MemReady = 1'b0;
        #1;
        n_checks++;
        if (State !== 4'(S_MEM_RD) || MemRead !== 1'b1 || IorD !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre got state=%0d rd=%b iord=%b want 4/1/1", State, MemRead, IorD);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 18'd0 || State !== 4'(S_IDLE) || InstrCount !== '0) begin
            n_fail++;
            $display("FAIL abort_async got out=%b state=%0d cnt=%0d want 0/0/0", obs, State, InstrCount);
        end
        MemReady = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (Retire !== 1'b0 || State !== 4'(S_IDLE)) begin
            n_fail++;
            $display("FAIL abort_hold got ret=%b state=%0d want 0/0", Retire, State);
        end
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(6'b000000, 0, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cnt_model = 0;
        rst_n     = 1'b0;
        Opcode    = 6'd0;
        Zero      = 1'b0;
        MemReady  = 1'b0;
        test_reset;
        test_r_type;
        test_lw_waits;
        test_sw_beq;
        test_itype_jump;
        test_random;
        test_trap;
        test_wrap;
        test_async_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
